// File: rtl/store_buffer_pkg.sv
// Shared widths, store-size encodings, entry payload and drain FSM states.
package store_buffer_pkg;

  localparam int unsigned ADDR_SIZE = 32;
  localparam int unsigned WORD_LEN  = 32;
  localparam int unsigned BE_W      = WORD_LEN / 8;
  localparam int unsigned DEPTH_DEF = 4;

  // stSize encodings; 2'b11 is illegal
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } drain_state_e;

  // One buffered store: word address, lane-aligned data, byte enables
  typedef struct packed {
    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_LEN-1:0]  data;
    logic [BE_W-1:0]      be;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// CPU store port, memory write port and load-hazard probe of the store buffer.
interface store_buffer_if #(
  parameter int unsigned DEPTH = store_buffer_pkg::DEPTH_DEF
);
  import store_buffer_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                 stValid;
  logic                 stReady;
  logic [ADDR_SIZE-1:0] stAddr;
  logic [WORD_LEN-1:0]  stData;
  logic [1:0]           stSize;
  logic                 memReq;
  logic [ADDR_SIZE-1:0] memAddr;
  logic [WORD_LEN-1:0]  memWData;
  logic [BE_W-1:0]      memByteEn;
  logic                 memAck;
  logic [ADDR_SIZE-1:0] ldAddr;
  logic                 ldHazard;
  logic                 misaligned;
  logic                 empty;
  logic [CW-1:0]        count;

  // Buffer side
  modport slave (
    input  stValid, stAddr, stData, stSize, memAck, ldAddr,
    output stReady, memReq, memAddr, memWData, memByteEn,
           ldHazard, misaligned, empty, count
  );

  // CPU / memory side
  modport master (
    output stValid, stAddr, stData, stSize, memAck, ldAddr,
    input  stReady, memReq, memAddr, memWData, memByteEn,
           ldHazard, misaligned, empty, count
  );

endinterface

// File: rtl/store_lane_align.sv
// Lane alignment, byte-enable generation and misalignment check for one store.
module store_lane_align
  import store_buffer_pkg::*;
(
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic [WORD_LEN-1:0]  data_i,
  input  logic [1:0]           size_i,
  output logic [ADDR_SIZE-1:0] word_addr_c,
  output logic [WORD_LEN-1:0]  wdata_c,
  output logic [BE_W-1:0]      byte_en_c,
  output logic                 misaligned_c
);

  // Replicate narrow data across lanes and pick the enabled bytes
  always_comb begin
    word_addr_c  = {addr_i[ADDR_SIZE-1:2], 2'b00};
    wdata_c      = data_i;
    byte_en_c    = '1;
    misaligned_c = 1'b0;
    case (size_i)
      SIZE_B: begin
        wdata_c   = {4{data_i[7:0]}};
        byte_en_c = BE_W'(1) << addr_i[1:0];
      end
      SIZE_H: begin
        wdata_c      = {2{data_i[15:0]}};
        byte_en_c    = addr_i[1] ? 4'b1100 : 4'b0011;
        misaligned_c = addr_i[0];
      end
      SIZE_W: begin
        misaligned_c = (addr_i[1:0] != 2'b00);
      end
      default: begin
        misaligned_c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: FIFO of aligned stores drained by a two-state write FSM.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  store_buffer_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  drain_state_e         state_q, state_d;
  sb_entry_t            entry_q [DEPTH];
  sb_entry_t            entry_d [DEPTH];
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 mem_req_q, mem_req_d;
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_LEN-1:0]  mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]      mem_be_q, mem_be_d;
  logic                 misaligned_q, misaligned_d;

  logic [ADDR_SIZE-1:0] al_addr_c;
  logic [WORD_LEN-1:0]  al_data_c;
  logic [BE_W-1:0]      al_be_c;
  logic                 al_mis_c;
  logic                 st_ready_c;
  logic                 st_fire_c;
  logic                 enq_c;
  logic                 pop_c;
  logic                 load_c;
  logic                 hazard_c;

  store_lane_align u_align (
    .addr_i       (bus.stAddr),
    .data_i       (bus.stData),
    .size_i       (bus.stSize),
    .word_addr_c  (al_addr_c),
    .wdata_c      (al_data_c),
    .byte_en_c    (al_be_c),
    .misaligned_c (al_mis_c)
  );

  // Handshake decode; a full buffer never accepts, even when popping this edge
  always_comb begin
    st_ready_c = (count_q < CW'(DEPTH));
    st_fire_c  = bus.stValid && st_ready_c;
    enq_c      = st_fire_c && !al_mis_c;
    pop_c      = (state_q == S_REQ) && bus.memAck;
    load_c     = (state_q == S_IDLE) && (count_q != '0);
  end

  // Drain FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Drain FSM next state: IDLE loads the head, REQ waits for the ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_REQ;
      S_REQ:   if (bus.memAck) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO update and registered memory-port outputs
  always_comb begin
    entry_d      = entry_q;
    valid_d      = valid_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    mem_req_d    = (state_d == S_REQ);
    misaligned_d = st_fire_c && al_mis_c;

    if (load_c) begin
      mem_addr_d  = entry_q[head_q].addr;
      mem_wdata_d = entry_q[head_q].data;
      mem_be_d    = entry_q[head_q].be;
    end

    if (pop_c) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end

    if (enq_c) begin
      entry_d[tail_q] = '{addr: al_addr_c, data: al_data_c, be: al_be_c};
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PW'(1);
    end

    case ({enq_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= '0;
      valid_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      misaligned_q <= 1'b0;
    end else begin
      entry_q      <= entry_d;
      valid_q      <= valid_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Load hazard: any valid entry, including the one in flight, in the load's word
  always_comb begin
    hazard_c = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && (entry_q[i].addr[ADDR_SIZE-1:2] == bus.ldAddr[ADDR_SIZE-1:2]))
        hazard_c = 1'b1;
    end
  end

  assign bus.stReady    = st_ready_c;
  assign bus.memReq     = mem_req_q;
  assign bus.memAddr    = mem_addr_q;
  assign bus.memWData   = mem_wdata_q;
  assign bus.memByteEn  = mem_be_q;
  assign bus.ldHazard   = hazard_c;
  assign bus.misaligned = misaligned_q;
  assign bus.empty      = (count_q == '0);
  assign bus.count      = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a queue-based reference model.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH)) bus ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } exp_t;

  exp_t q[$];
  bit   req_m;
  bit   mis_m;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mis(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic exp_t align(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    exp_t e;
    e.a = a & ~32'h3;
    if (s == 2'd0) begin
      e.d  = 32'(d[7:0]) * 32'h01010101;
      e.be = 4'(1 << a[1:0]);
    end else if (s == 2'd1) begin
      e.d  = 32'(d[15:0]) * 32'h00010001;
      e.be = a[1] ? 4'hC : 4'h3;
    end else begin
      e.d  = d;
      e.be = 4'hF;
    end
    return e;
  endfunction

  // Advance the model across one rising edge using the inputs held before it
  task automatic model_edge();
    int n;
    bit pop;
    bit acc;
    if (rst) begin
      q.delete();
      req_m = 1'b0;
      mis_m = 1'b0;
      return;
    end
    n   = q.size();
    pop = req_m && bus.memAck;
    acc = bus.stValid && (n < int'(DEPTH));
    if (pop) void'(q.pop_front());
    mis_m = acc && is_mis(bus.stAddr, bus.stSize);
    if (acc && !mis_m) q.push_back(align(bus.stAddr, bus.stData, bus.stSize));
    req_m = req_m ? !bus.memAck : (n != 0);
  endtask

  // Every-cycle comparison of all outputs against the model
  task automatic compare();
    bit hz;
    hz = 1'b0;
    foreach (q[i]) if (q[i].a[31:2] == bus.ldAddr[31:2]) hz = 1'b1;
    chk("m_count",      32'(bus.count),      q.size());
    chk("m_empty",      32'(bus.empty),      32'(q.size() == 0));
    chk("m_stReady",    32'(bus.stReady),    32'(q.size() < int'(DEPTH)));
    chk("m_ldHazard",   32'(bus.ldHazard),   32'(hz));
    chk("m_misaligned", 32'(bus.misaligned), 32'(mis_m));
    chk("m_memReq",     32'(bus.memReq),     32'(req_m));
    if (req_m && q.size() != 0) begin
      chk("m_memAddr",   bus.memAddr,          q[0].a);
      chk("m_memWData",  bus.memWData,         q[0].d);
      chk("m_memByteEn", 32'(bus.memByteEn),   32'(q[0].be));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bus.stValid = 1'b1;
    bus.stAddr  = a;
    bus.stData  = d;
    bus.stSize  = s;
    cycle();
    bus.stValid = 1'b0;
  endtask

  task automatic drain_one(input logic [31:0] ea);
    int w;
    w = 0;
    while (!bus.memReq && w < 8) begin
      cycle();
      w++;
    end
    chk("drain_req", 32'(bus.memReq), 32'd1);
    chk("drain_addr", bus.memAddr, ea);
    bus.memAck = 1'b1;
    cycle();
    bus.memAck = 1'b0;
  endtask

  initial begin
    bus.stValid = 1'b0;
    bus.stAddr  = '0;
    bus.stData  = '0;
    bus.stSize  = 2'd0;
    bus.memAck  = 1'b0;
    bus.ldAddr  = 32'hFFFF_FFF0;

    // Reset values
    @(negedge clk);
    chk("rst_empty",   32'(bus.empty),    32'd1);
    chk("rst_stReady", 32'(bus.stReady),  32'd1);
    chk("rst_hazard",  32'(bus.ldHazard), 32'd0);
    chk("rst_memReq",  32'(bus.memReq),   32'd0);
    chk("rst_count",   32'(bus.count),    32'd0);
    rst = 1'b0;
    cycle();

    // Single byte store
    store(32'h102, 32'h0000_00AB, 2'd0);
    chk("sb_count", 32'(bus.count), 32'd1);
    chk("sb_req0",  32'(bus.memReq), 32'd0);
    cycle();
    chk("sb_req1",  32'(bus.memReq),    32'd1);
    chk("sb_addr",  bus.memAddr,        32'h100);
    chk("sb_be",    32'(bus.memByteEn), 32'h4);
    chk("sb_data",  bus.memWData,       32'hABAB_ABAB);
    bus.memAck = 1'b1;
    cycle();
    bus.memAck = 1'b0;
    chk("sb_empty", 32'(bus.empty), 32'd1);

    // Fill without acks, then drain in order
    for (int k = 0; k < 4; k++) store(32'h10 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1), 2'd2);
    chk("fill_count", 32'(bus.count),   32'd4);
    chk("fill_ready", 32'(bus.stReady), 32'd0);
    store(32'h20, 32'h5555_5555, 2'd2);
    chk("fill_5th",   32'(bus.count),   32'd4);
    for (int k = 0; k < 4; k++) drain_one(32'h10 + 32'(4 * k));
    chk("fill_empty", 32'(bus.empty), 32'd1);

    // Misaligned stores are dropped with a one-cycle pulse
    store(32'h201, 32'h1234, 2'd1);
    chk("mis_h_pulse", 32'(bus.misaligned), 32'd1);
    chk("mis_h_count", 32'(bus.count),      32'd0);
    cycle();
    chk("mis_h_clear", 32'(bus.misaligned), 32'd0);
    store(32'h202, 32'h1234_5678, 2'd2);
    chk("mis_w_pulse", 32'(bus.misaligned), 32'd1);
    store(32'h200, 32'h0, 2'd3);
    chk("mis_ill_pulse", 32'(bus.misaligned), 32'd1);
    cycle();
    cycle();
    chk("mis_no_req", 32'(bus.memReq), 32'd0);

    // Half-word lane check
    store(32'h222, 32'h0000_BEEF, 2'd1);
    cycle();
    chk("sh_data", bus.memWData,       32'hBEEF_BEEF);
    chk("sh_be",   32'(bus.memByteEn), 32'hC);
    drain_one(32'h220);

    // Load hazard
    store(32'h300, 32'hDEAD_BEEF, 2'd2);
    bus.ldAddr = 32'h303;
    #1 chk("hz_hit", 32'(bus.ldHazard), 32'd1);
    bus.ldAddr = 32'h304;
    #1 chk("hz_miss", 32'(bus.ldHazard), 32'd0);
    bus.ldAddr = 32'h303;
    drain_one(32'h300);
    #1 chk("hz_after_ack", 32'(bus.ldHazard), 32'd0);
    bus.ldAddr = 32'hFFFF_FFF0;

    // Simultaneous enqueue and pop; ack held high pops only once per transfer
    store(32'h400, 32'hA0, 2'd2);
    store(32'h404, 32'hA4, 2'd2);
    chk("sim_count2", 32'(bus.count), 32'd2);
    bus.memAck = 1'b1;
    store(32'h408, 32'hA8, 2'd2);
    chk("sim_both", 32'(bus.count), 32'd2);
    for (int k = 0; k < 3; k++) cycle();
    bus.memAck = 1'b0;
    chk("sim_one_pop", 32'(bus.count), 32'd1);
    drain_one(32'h408);

    // Reset while a request is outstanding
    for (int k = 0; k < 3; k++) store(32'h500 + 32'(4 * k), 32'hC0 + 32'(k), 2'd2);
    bus.ldAddr = 32'h500;
    chk("rq_req", 32'(bus.memReq), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rq_req_drop", 32'(bus.memReq),   32'd0);
    chk("rq_count",    32'(bus.count),    32'd0);
    chk("rq_empty",    32'(bus.empty),    32'd1);
    chk("rq_ready",    32'(bus.stReady),  32'd1);
    chk("rq_hazard",   32'(bus.ldHazard), 32'd0);
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    chk("rq_no_retry", 32'(bus.memReq), 32'd0);
    store(32'h600, 32'h77, 2'd0);
    drain_one(32'h600);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
